// File: rtl/shake_sponge_ctrl_if.sv
// Handshake bundle between the SHAKE256 sponge sequencer and its neighbours:
// the host command interface, the message accumulator, the state/permutation
// datapath and the squeeze output consumer.
//   master : host/environment side (drives commands and datapath status)
//   slave  : sequencer side (drives strobes, squeeze valid and status)
interface shake_sponge_ctrl_if #(
    parameter int BLKCNT_W = 16,
    parameter int OUTCNT_W = 8
);
    // host command / status
    logic                start;
    logic                msg_end;
    logic [OUTCNT_W-1:0] out_blocks;
    logic                busy;
    logic                done;
    logic [BLKCNT_W-1:0] blk_count;
    // accumulator
    logic                accumulate_start;
    logic                is_final_chunk;
    logic                block_ready;
    logic                partial_block;
    // state register / permutation core
    logic                state_clear;
    logic                absorb_en;
    logic                perm_start;
    logic                perm_done;
    // squeeze output
    logic                sq_valid;
    logic                sq_ready;

    modport master (
        output start, msg_end, out_blocks, block_ready, partial_block,
               perm_done, sq_ready,
        input  accumulate_start, is_final_chunk, state_clear, absorb_en,
               perm_start, sq_valid, busy, done, blk_count
    );

    modport slave (
        input  start, msg_end, out_blocks, block_ready, partial_block,
               perm_done, sq_ready,
        output accumulate_start, is_final_chunk, state_clear, absorb_en,
               perm_start, sq_valid, busy, done, blk_count
    );
endinterface

// File: rtl/shake_sponge_ctrl.sv
// SHAKE256 sponge sequencer.
// Clears the state on start, then loops accumulate -> absorb -> permute until
// the final (padded) block has been absorbed, then meters out_blocks squeeze
// blocks, running one extra permutation between consecutive squeeze blocks.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : shake_sponge_ctrl_if slave modport (all handshakes and status)
// All strobes are registered and asserted on entry to the state that owns
// them, so start->accumulate_start is 1 cycle, block_ready rise->perm_start
// is 2 cycles and perm_done->sq_valid is 1 cycle.
module shake_sponge_ctrl #(
    parameter int BLKCNT_W = 16,
    parameter int OUTCNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    shake_sponge_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE, ACC_GO, ACC_WAIT, ABSORB, PERM_GO, PERM_WAIT, SQ, DONE
    } state_t;

    state_t              state;
    logic                block_ready_q;
    logic                final_q;      // host has signalled end of message
    logic                last_absorb;  // absorbed block was the padded final one
    logic                squeezing;    // absorption finished; perms are squeeze perms
    logic [OUTCNT_W-1:0] sq_left;
    logic                blk_rise;

    // Only a fresh rising edge counts: a level left high from the previous
    // block must not be absorbed twice.
    assign blk_rise           = bus.block_ready & ~block_ready_q;
    assign bus.is_final_chunk = final_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            block_ready_q        <= 1'b0;
            final_q              <= 1'b0;
            last_absorb          <= 1'b0;
            squeezing            <= 1'b0;
            sq_left              <= '0;
            bus.blk_count        <= '0;
            bus.accumulate_start <= 1'b0;
            bus.state_clear      <= 1'b0;
            bus.absorb_en        <= 1'b0;
            bus.perm_start       <= 1'b0;
            bus.sq_valid         <= 1'b0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
        end else begin
            block_ready_q        <= bus.block_ready;
            bus.accumulate_start <= 1'b0;
            bus.state_clear      <= 1'b0;
            bus.absorb_en        <= 1'b0;
            bus.perm_start       <= 1'b0;
            bus.done             <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (bus.start) begin
                        state                <= ACC_GO;
                        bus.state_clear      <= 1'b1;
                        bus.accumulate_start <= 1'b1;
                        sq_left              <= (bus.out_blocks == '0) ?
                                                OUTCNT_W'(1) : bus.out_blocks;
                        bus.blk_count        <= '0;
                        final_q              <= 1'b0;
                        last_absorb          <= 1'b0;
                        squeezing            <= 1'b0;
                        bus.busy             <= 1'b1;
                    end
                end
                ACC_GO: state <= ACC_WAIT;
                ACC_WAIT: begin
                    final_q <= final_q | bus.msg_end;
                    if (blk_rise) begin
                        state         <= ABSORB;
                        bus.absorb_en <= 1'b1;
                    end
                end
                ABSORB: begin
                    state          <= PERM_GO;
                    bus.perm_start <= 1'b1;
                    last_absorb    <= final_q & bus.partial_block;
                    if (!(&bus.blk_count))
                        bus.blk_count <= bus.blk_count + 1'b1;
                end
                PERM_GO: state <= PERM_WAIT;
                PERM_WAIT: begin
                    if (bus.perm_done) begin
                        // A final block that was full still needs a pad-only
                        // block; final_q stays set so the accumulator pads it.
                        if (!squeezing && !last_absorb) begin
                            state                <= ACC_GO;
                            bus.accumulate_start <= 1'b1;
                        end else begin
                            state        <= SQ;
                            bus.sq_valid <= 1'b1;
                            squeezing    <= 1'b1;
                        end
                    end
                end
                SQ: begin
                    if (bus.sq_ready) begin
                        bus.sq_valid <= 1'b0;
                        sq_left      <= sq_left - 1'b1;
                        if (sq_left == OUTCNT_W'(1)) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end else begin
                            state          <= PERM_GO;
                            bus.perm_start <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shake_sponge_ctrl.sv
module tb_shake_sponge_ctrl;
    localparam int BW = 16;
    localparam int OW = 8;

    typedef struct {
        byte kind;
        int  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_absorb = 0;
    exp_t exp_q[$];

    shake_sponge_ctrl_if #(.BLKCNT_W(BW), .OUTCNT_W(OW)) bus ();

    shake_sponge_ctrl #(.BLKCNT_W(BW), .OUTCNT_W(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic ex(input byte k, input int d);
        exp_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every strobe / handshake pops the next expected event
    task automatic mon_ev(input byte k, input int d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %c(%0d) expected none", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d) begin
                errors++;
                $display("FAIL event_seq: got %c(%0d) expected %c(%0d)",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.state_clear)             mon_ev("C", 0);
            if (bus.accumulate_start)        mon_ev("A", int'(bus.is_final_chunk));
            if (bus.absorb_en) begin
                n_absorb++;
                mon_ev("B", 0);
            end
            if (bus.perm_start)              mon_ev("P", 0);
            if (bus.sq_valid && bus.sq_ready) mon_ev("S", 0);
            if (bus.done)                    mon_ev("D", int'(bus.blk_count));
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0: return bus.accumulate_start;
            1: return bus.perm_start;
            2: return bus.sq_valid;
            default: return bus.done;
        endcase
    endfunction

    // Returns at the negedge where the selected output is high.
    task automatic wait_for(input int w, input string name);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sel(w)) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_%s: got no pulse expected pulse", name);
    endtask

    task automatic do_start(input int ob);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.out_blocks = OW'(ob);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Accumulator model; a stray perm_done is injected while in ACC_WAIT.
    task automatic feed_block(input logic fin, input logic part,
                              input logic drop, input logic hold_chk);
        int snap;
        wait_for(0, "acc_start");
        @(posedge clk);
        if (hold_chk) begin
            snap = n_absorb;
            repeat (10) @(posedge clk);
            chk("held_ready_no_absorb", n_absorb, snap);
            #1 bus.block_ready = 1'b0;
            @(posedge clk);
        end
        #1 bus.msg_end = fin;
        bus.partial_block = part;
        bus.perm_done = 1'b1;
        @(posedge clk);
        #1 bus.perm_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.block_ready = 1'b1;
        @(posedge clk);
        #1 if (drop) bus.block_ready = 1'b0;
    endtask

    task automatic run_perm();
        wait_for(1, "perm_start");
        repeat (24) @(posedge clk);
        #1 bus.perm_done = 1'b1;
        @(posedge clk);
        #1 bus.perm_done = 1'b0;
    endtask

    task automatic finish_hash(input string name, input int nblk);
        wait_for(3, "done");
        @(posedge clk);
        #1 chk({name, "_busy_low"}, int'(bus.busy), 0);
        chk({name, "_blk_count"}, int'(bus.blk_count), nblk);
        repeat (5) @(posedge clk);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
        bus.msg_end = 1'b0;
        bus.partial_block = 1'b0;
        bus.block_ready = 1'b0;
        bus.sq_ready = 1'b0;
    endtask

    task automatic short_msg(input string name, input int ob);
        ex("C", 0); ex("A", 0); ex("B", 0); ex("P", 0); ex("S", 0); ex("D", 1);
        bus.msg_end = 1'b1;
        bus.sq_ready = 1'b1;
        do_start(ob);
        chk({name, "_busy_high"}, int'(bus.busy), 1);
        feed_block(1'b1, 1'b1, 1'b1, 1'b0);
        run_perm();
        finish_hash(name, 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.msg_end = 1'b0;
        bus.out_blocks = '0;
        bus.block_ready = 1'b0;
        bus.partial_block = 1'b0;
        bus.perm_done = 1'b0;
        bus.sq_ready = 1'b0;
        #22;
        chk("reset_outputs",
            int'({bus.accumulate_start, bus.is_final_chunk, bus.state_clear,
                  bus.absorb_en, bus.perm_start, bus.sq_valid, bus.busy, bus.done}), 0);
        chk("reset_blk_count", int'(bus.blk_count), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // short message, single partial final block
        short_msg("short", 1);

        // two full blocks, end flagged during the second -> pad-only third block
        ex("C", 0); ex("A", 0); ex("B", 0); ex("P", 0);
        ex("A", 0); ex("B", 0); ex("P", 0);
        ex("A", 1); ex("B", 0); ex("P", 0); ex("S", 0); ex("D", 3);
        bus.sq_ready = 1'b1;
        do_start(1);
        feed_block(1'b0, 1'b0, 1'b1, 1'b0);
        run_perm();
        feed_block(1'b1, 1'b0, 1'b1, 1'b0);
        run_perm();
        feed_block(1'b1, 1'b1, 1'b1, 1'b0);
        run_perm();
        finish_hash("boundary", 3);

        // three squeeze blocks with a stalling consumer and a start while busy
        ex("C", 0); ex("A", 0); ex("B", 0); ex("P", 0);
        ex("S", 0); ex("P", 0); ex("S", 0); ex("P", 0); ex("S", 0); ex("D", 1);
        bus.msg_end = 1'b1;
        do_start(3);
        feed_block(1'b1, 1'b1, 1'b1, 1'b0);
        run_perm();
        for (int k = 0; k < 3; k++) begin
            wait_for(2, "sq_valid");
            @(posedge clk);
            #1 if (k == 0) bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            chk("sq_valid_held", int'(bus.sq_valid), 1);
            bus.sq_ready = 1'b1;
            @(posedge clk);
            #1 bus.sq_ready = 1'b0;
            chk("sq_valid_drops", int'(bus.sq_valid), 0);
            if (k < 2) run_perm();
        end
        finish_hash("multi_sq", 1);

        // out_blocks = 0 behaves as 1
        short_msg("zero_out", 0);

        // block_ready held high across the next ACC_GO
        ex("C", 0); ex("A", 0); ex("B", 0); ex("P", 0);
        ex("A", 0); ex("B", 0); ex("P", 0); ex("S", 0); ex("D", 2);
        bus.sq_ready = 1'b1;
        do_start(1);
        feed_block(1'b0, 1'b0, 1'b0, 1'b0);
        run_perm();
        feed_block(1'b1, 1'b1, 1'b1, 1'b1);
        run_perm();
        finish_hash("held", 2);

        // reset during PERM_WAIT, then a normal hash
        ex("C", 0); ex("A", 0); ex("B", 0); ex("P", 0);
        do_start(1);
        feed_block(1'b0, 1'b0, 1'b1, 1'b0);
        wait_for(1, "perm_start");
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_reset_outputs",
               int'({bus.accumulate_start, bus.is_final_chunk, bus.state_clear,
                     bus.absorb_en, bus.perm_start, bus.sq_valid, bus.busy,
                     bus.done}), 0);
        chk("async_reset_queue", exp_q.size(), 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        short_msg("after_reset", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shake_sponge_ctrl.md
Name: shake_sponge_ctrl

Overview:
- Top-level sequencer for the SHAKE256 sponge.
- Drives the message accumulator (start/final handshake) and issues state-clear and absorb (XOR) strobes to the state register.
- Starts the Keccak-f permutation core and meters squeeze output blocks to the consumer.
- Sits between the host command interface, the accumulator, the state/permutation datapath and the output serializer.

Parameters:
- BLKCNT_W, 16, width of absorbed-block counter.
- OUTCNT_W, 8, width of the requested squeeze-block count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin new hash; ignored unless busy=0.
- msg_end  in  1  level: host has issued serial_end_signal for the last chunk; sampled while waiting on the accumulator.
- out_blocks  in  OUTCNT_W  number of 1088-bit squeeze blocks requested; latched on start; 0 treated as 1.
- accumulate_start  out  1  one-cycle pulse to accumulator.
- is_final_chunk  out  1  level to accumulator; equals latched final flag.
- block_ready  in  1  accumulator block complete (level; rising edge used).
- partial_block  in  1  accumulator block was padded/partial.
- state_clear  out  1  one-cycle pulse: zero 1600-bit state.
- absorb_en  out  1  one-cycle pulse: XOR block_data into state rate lanes.
- perm_start  out  1  one-cycle pulse to permutation core.
- perm_done  in  1  one-cycle pulse from permutation core.
- sq_valid  out  1  squeeze block available on state rate lanes.
- sq_ready  in  1  consumer accepts block when sq_valid & sq_ready.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last squeeze handshake.
- blk_count  out  BLKCNT_W  blocks absorbed in current hash, saturating at all-ones.

Behaviour:
- Reset (async): state IDLE; all outputs 0; final flag, counters and block_ready edge register cleared.
- Edge detect: blk_rise = block_ready & ~block_ready_q. Only blk_rise advances absorption; a level held high from a previous block is ignored.
- IDLE:
  - On start: state_clear=1, latch out_blocks (0 becomes 1) into sq_left, clear blk_count and final flag, busy=1.
  - Go to ACC_GO.
- ACC_GO: accumulate_start=1 for one cycle → ACC_WAIT.
- ACC_WAIT:
  - Every cycle, final flag |= msg_end. is_final_chunk reflects the flag combinationally from the register.
  - On blk_rise → ABSORB.
- ABSORB:
  - absorb_en=1 for one cycle; blk_count+1 (saturating) → PERM_GO.
  - Record last_absorb = final flag & partial_block.
- PERM_GO: perm_start=1 for one cycle → PERM_WAIT.
- PERM_WAIT: on perm_done:
  - If still absorbing and last_absorb=0 → ACC_GO. This covers the non-final case, and the final-but-full case (message ended on a 136-byte boundary), which needs a pad-only block. Final flag stays 1 so the accumulator pads.
  - Else → SQ.
- SQ:
  - sq_valid=1; held until the handshake.
  - On sq_valid & sq_ready: sq_left−1. If the new value is 0 → DONE, else → PERM_GO (squeeze permutation; sq_valid low during it).
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Latency:
  - start to first accumulate_start: 1 cycle.
  - blk_rise to perm_start: 2 cycles.
  - perm_done to sq_valid: 1 cycle.
- Boundaries:
  - start while busy=1 is ignored.
  - msg_end asserted before first block: the first block is final.
  - perm_done outside PERM_WAIT is ignored.
  - blk_rise outside ACC_WAIT is ignored, but block_ready_q still tracks.
  - sq_ready without sq_valid has no effect.
  - reset mid-operation aborts immediately to IDLE with all strobes low. The state register is not cleared by this block until the next start.
- Arithmetic: sq_left is OUTCNT_W bits and never underflows, because exit at 1→0 is enforced. blk_count saturates.

Test Plan:
- Short message: start, out_blocks=1, msg_end high before block_ready, partial_block=1, perm_done 24 cycles after perm_start, sq_ready=1 → exactly one absorb_en and two perm_start? No: 1 absorb_en, 1 perm_start, sq_valid 1 cycle, done pulse, blk_count=1.
- Boundary message: two full blocks (partial_block=0), msg_end during the second → third accumulate_start with is_final_chunk=1; after a partial third block, blk_count=3 and sq_valid follows.
- Multi-squeeze: out_blocks=3, sq_ready toggling 0/1 → sq_valid held until accepted; 3 handshakes, 2 extra perm_start in SQ phase, then done.
- out_blocks=0 → behaves as 1; exactly one squeeze handshake.
- Held block_ready: block_ready stays high across the next ACC_GO → no second absorb_en until it falls and rises again.
- Reset asserted during PERM_WAIT → all outputs 0 asynchronously; a new start after reset produces a state_clear pulse and a normal sequence.
